// File: rtl/bank_group_arbiter.sv
// bank_group_arbiter
// Two-level round-robin arbiter over 16 bank queues arranged as 4 groups of
// 4 banks. A registered selection (group_sel/bank_sel) is presented with
// out_valid and held stable until accepted by out_ready. On acceptance, a
// one-cycle combinational pop pulse goes to the granted queue. The arbiter
// stays in one group for up to BURST_MAX consecutive grants before it must
// rotate to another requesting group.
//
// Handshake: a selection transfers on any rising edge where
// out_valid && out_ready (and rst is low). While out_valid is high and
// out_ready is low, the selection does not change. Requesters keep their
// req_valid bit high until they see their grant bit.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [15:0] per-bank non-empty flags, bit 4*g+b = group g, bank b
//   out_ready  in   downstream accepts the current selection
//   out_valid  out  registered, selection valid
//   group_sel  out  [1:0] registered selected group
//   bank_sel   out  [7:0] registered, field [2g+1:2g] = bank for group g
//   grant      out  [15:0] one-hot pop pulse, high only during a handshake
module bank_group_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_valid,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [1:0]  group_sel,
    output logic [7:0]  bank_sel,
    output logic [15:0] grant
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [1:0]      group_sel_q, group_sel_d;
    logic [3:0][1:0] bank_sel_q, bank_sel_d;
    logic [3:0][1:0] rr_bank_q, nx_rr_bank;
    logic [1:0]      rr_group_q, nx_rr_group;
    logic [3:0]      burst_q, nx_burst;

    logic            hs;
    logic            load;
    logic [1:0]      granted_bank;
    logic [15:0]     masked;
    logic [3:0]      group_has;
    logic            cand;
    logic [1:0]      pick_group;
    logic            bank_found;
    logic [1:0]      pick_bank;
    logic [1:0]      g_try;
    logic [1:0]      b_try;

    assign out_valid = (state_q == HOLD);
    assign group_sel = group_sel_q;
    assign bank_sel  = bank_sel_q;

    always_comb begin
        // Handshake is suppressed by reset so a discarded selection never pops.
        hs           = (state_q == HOLD) && out_ready && !rst;
        granted_bank = bank_sel_q[group_sel_q];
        grant        = 16'h0000;
        if (hs) begin
            grant[{group_sel_q, granted_bank}] = 1'b1;
        end

        // Post-handshake pointer values; the reload decision uses these.
        nx_rr_bank  = rr_bank_q;
        nx_rr_group = rr_group_q;
        nx_burst    = burst_q;
        if (hs) begin
            nx_rr_group             = group_sel_q;
            nx_rr_bank[group_sel_q] = granted_bank;
            if (group_sel_q == rr_group_q) begin
                nx_burst = (burst_q >= BMAX) ? BMAX : burst_q + 4'd1;
            end else begin
                nx_burst = 4'd1;
            end
        end

        // The just-popped bank may still show req_valid this edge; ignore it.
        masked = req_valid & ~grant;
        for (int g = 0; g < 4; g++) begin
            group_has[g] = |masked[4*g +: 4];
        end

        // Group choice: stay while burst budget remains, else rotate, else
        // fall back to the current group if it is the only one requesting.
        cand       = 1'b0;
        pick_group = nx_rr_group;
        g_try      = nx_rr_group;
        if (group_has[nx_rr_group] && (nx_burst < BMAX)) begin
            cand = 1'b1;
        end else begin
            for (int k = 1; k < 4; k++) begin
                g_try = nx_rr_group + 2'(k);
                if (!cand && group_has[g_try]) begin
                    cand       = 1'b1;
                    pick_group = g_try;
                end
            end
            if (!cand && group_has[nx_rr_group]) begin
                cand       = 1'b1;
                pick_group = nx_rr_group;
            end
        end

        // Bank choice: first requester after the group's last-granted bank.
        bank_found = 1'b0;
        pick_bank  = nx_rr_bank[pick_group];
        b_try      = nx_rr_bank[pick_group];
        for (int k = 1; k <= 4; k++) begin
            b_try = nx_rr_bank[pick_group] + 2'(k);
            if (!bank_found && masked[{pick_group, b_try}]) begin
                bank_found = 1'b1;
                pick_bank  = b_try;
            end
        end

        load        = (state_q == EMPTY) || hs;
        state_d     = state_q;
        group_sel_d = group_sel_q;
        bank_sel_d  = bank_sel_q;
        if (load) begin
            state_d                = cand ? HOLD : EMPTY;
            group_sel_d            = pick_group;
            bank_sel_d             = nx_rr_bank;
            bank_sel_d[pick_group] = pick_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            group_sel_q <= 2'd0;
            bank_sel_q  <= '0;
            rr_bank_q   <= {4{2'd3}};
            rr_group_q  <= 2'd3;
            burst_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            group_sel_q <= group_sel_d;
            bank_sel_q  <= bank_sel_d;
            rr_bank_q   <= nx_rr_bank;
            rr_group_q  <= nx_rr_group;
            burst_q     <= nx_burst;
        end
    end

endmodule

// File: tb/tb_bank_group_arbiter.sv
// Directed bench for bank_group_arbiter: u_dut uses BURST_MAX=4, u_dut2 uses
// BURST_MAX=2 for the burst-rotation sequence. Inputs change 1 time unit
// after the rising edge; outputs are sampled there too.
module tb_bank_group_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_valid;
    logic        out_ready;
    logic        out_valid;
    logic [1:0]  group_sel;
    logic [7:0]  bank_sel;
    logic [15:0] grant;

    logic [15:0] req2;
    logic        rdy2;
    logic        v2;
    logic [1:0]  g2;
    logic [7:0]  b2;
    logic [15:0] gr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_group_arbiter #(.BURST_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .out_ready(out_ready),
        .out_valid(out_valid), .group_sel(group_sel), .bank_sel(bank_sel),
        .grant(grant)
    );

    bank_group_arbiter #(.BURST_MAX(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req2), .out_ready(rdy2),
        .out_valid(v2), .group_sel(g2), .bank_sel(b2), .grant(gr2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 16'h0000; out_ready = 1'b0;
        req2 = 16'h0000; rdy2 = 1'b0;

        // Reset state
        step(); step();
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_group", 16'(group_sel), 16'h0);
        check("rst_bank",  16'(bank_sel),  16'h00);
        out_ready = 1'b1; #1;
        check("rst_grant", grant, 16'h0000);

        // Single request, one-cycle latency, grant, then drain to EMPTY
        rst = 1'b0; out_ready = 1'b0; req_valid = 16'h0001;
        step();
        check("a_valid", 16'(out_valid), 16'h1);
        check("a_group", 16'(group_sel), 16'h0);
        check("a_bank0", 16'(bank_sel[1:0]), 16'h0);
        check("a_nogrant", grant, 16'h0000);
        out_ready = 1'b1; #1;
        check("a_grant", grant, 16'h0001);
        req_valid = 16'h0000;
        step();
        check("a_empty", 16'(out_valid), 16'h0);
        check("a_empty_grant", grant, 16'h0000);

        // Hold stable under back-pressure while another request arrives
        out_ready = 1'b0; req_valid = 16'h0001;
        step();
        check("b_valid", 16'(out_valid), 16'h1);
        req_valid = 16'h0021;
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_hold_valid", 16'(out_valid), 16'h1);
            check("b_hold_group", 16'(group_sel), 16'h0);
            check("b_hold_bank",  16'(bank_sel[1:0]), 16'h0);
            check("b_hold_grant", grant, 16'h0000);
        end
        out_ready = 1'b1; #1;
        check("b_grant0", grant, 16'h0001);
        step();
        check("b_group1", 16'(group_sel), 16'h1);
        check("b_bank1",  16'(bank_sel[3:2]), 16'h1);
        check("b_grant5", grant, 16'h0020);
        req_valid = 16'h0000;
        step();
        check("b_empty", 16'(out_valid), 16'h0);

        // Reset during a handshake: no grant, selection discarded
        out_ready = 1'b0; req_valid = 16'h0001;
        step();
        check("c_valid", 16'(out_valid), 16'h1);
        out_ready = 1'b1; rst = 1'b1; #1;
        check("c_rst_grant", grant, 16'h0000);
        step();
        check("c_rst_valid", 16'(out_valid), 16'h0);
        check("c_rst_group", 16'(group_sel), 16'h0);
        check("c_rst_bank",  16'(bank_sel), 16'h00);

        // Same single-request sequence reproduces after reset
        rst = 1'b0; out_ready = 1'b0; req_valid = 16'h0001;
        step();
        check("d_valid", 16'(out_valid), 16'h1);
        check("d_group", 16'(group_sel), 16'h0);
        check("d_bank0", 16'(bank_sel[1:0]), 16'h0);
        out_ready = 1'b1; #1;
        check("d_grant", grant, 16'h0001);
        req_valid = 16'h0000;
        step();
        check("d_empty", 16'(out_valid), 16'h0);

        // Four banks of group 0, one grant per cycle in bank order
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0; req_valid = 16'h000F; out_ready = 1'b1;
        step();
        check("e_grant0", grant, 16'h0001);
        step();
        check("e_grant1", grant, 16'h0002);
        step();
        check("e_grant2", grant, 16'h0004);
        step();
        check("e_grant3", grant, 16'h0008);
        check("e_group", 16'(group_sel), 16'h0);
        req_valid = 16'h0000; out_ready = 1'b0;

        // BURST_MAX=2: rotate groups after two grants
        req2 = 16'h0033; rdy2 = 1'b1;
        step();
        check("f_grant0", gr2, 16'h0001);
        step();
        check("f_grant1", gr2, 16'h0002);
        step();
        check("f_grant2", gr2, 16'h0010);
        check("f_group1", 16'(g2), 16'h1);
        step();
        check("f_grant3", gr2, 16'h0020);
        step();
        check("f_grant4", gr2, 16'h0001);
        check("f_group0", 16'(g2), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
